// File: rtl/fifo_read_arbiter_pkg.sv
// Shared types and defaults for the FIFO read-side arbiter.
// Burst FSM state type is used only when FRA_BURST_EN is defined.
package fifo_arb_pkg;

  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_DATA_W  = 8;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// FIFO read ports plus valid/ready output bundle.
// master = arbiter side, slave = FIFOs and consumer side.
interface fifo_read_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int DATA_W  = DEF_DATA_W
) ();

  localparam int SRC_W = src_w(NUM_SRC);

  logic [NUM_SRC-1:0]        fifo_empty;
  logic [NUM_SRC*DATA_W-1:0] fifo_rdata;
  logic [NUM_SRC-1:0]        fifo_pop;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [SRC_W-1:0]          out_src;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    input  out_ready,
    output fifo_pop,
    output out_valid,
    output out_data,
    output out_src
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    output out_ready,
    input  fifo_pop,
    input  out_valid,
    input  out_data,
    input  out_src
  );

endinterface

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Round-robin picker: first requester after i_ptr, wrapping.
// Pure combinational one-hot grant, grant index and any-request.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  localparam int SRC_W  = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [SRC_W-1:0]   i_ptr,
  output logic [NUM_SRC-1:0] o_gnt,
  output logic [SRC_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    j     = 0;
    // farthest first so the nearest requester is the last write
    for (int k = NUM_SRC; k >= 1; k--) begin
      j = (int'(i_ptr) + k) % NUM_SRC;
      if (i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = SRC_W'(j);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin scheduler popping NUM_SRC FIFOs into one valid/ready port.
// Define FRA_BURST_EN to keep a grant for up to BURST_LEN pops.
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_SRC   = DEF_NUM_SRC,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = 4
) (
  input logic             rclk,
  input logic             rst_n,
  fifo_read_arbiter_if.master bus
);

  localparam int SRC_W = src_w(NUM_SRC);

  if (NUM_SRC < 2 || BURST_LEN < 1) begin : g_bad_param
    $error("fifo_read_arbiter: bad parameters");
  end

  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [SRC_W-1:0]   r_src;
  logic [SRC_W-1:0]   r_ptr;

  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_rr_gnt;
  logic [SRC_W-1:0]   w_rr_idx;
  logic               w_any;
  logic               w_room;
  logic               w_load;
  logic [NUM_SRC-1:0] w_sel_gnt;
  logic [SRC_W-1:0]   w_sel_idx;

  assign w_req  = ~bus.fifo_empty;
  assign w_room = ~r_valid | bus.out_ready;
  assign w_load = w_room & w_any;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx),
    .o_any (w_any)
  );

`ifdef FRA_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nx;
  logic [SRC_W-1:0] r_lock;
  logic [SRC_W-1:0] w_lock_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_lock_hit;

  assign w_lock_hit = (r_state == LOCK) & ~bus.fifo_empty[r_lock];

  always_comb begin
    w_sel_idx  = w_rr_idx;
    w_sel_gnt  = w_rr_gnt;
    w_state_nx = r_state;
    w_lock_nx  = r_lock;
    w_cnt_nx   = r_cnt;
    if (w_lock_hit) begin
      w_sel_idx = r_lock;
      w_sel_gnt = NUM_SRC'(1) << r_lock;
      if (w_load) begin
        w_cnt_nx = r_cnt + 1'b1;
        if (r_cnt + 1'b1 == CNT_W'(BURST_LEN))
          w_state_nx = ARB;
      end
    end else if (w_load) begin
      // ARB, or LOCK whose FIFO ran dry: re-arbitrate now
      w_lock_nx  = w_rr_idx;
      w_cnt_nx   = CNT_W'(1);
      w_state_nx = (BURST_LEN > 1) ? LOCK : ARB;
    end else if (r_state == LOCK && w_room) begin
      w_state_nx = ARB;
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB;
      r_lock  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_lock  <= w_lock_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
`else
  assign w_sel_idx = w_rr_idx;
  assign w_sel_gnt = w_rr_gnt;
`endif

  assign bus.fifo_pop = (rst_n & w_load) ? w_sel_gnt : '0;

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= SRC_W'(NUM_SRC - 1);
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= bus.fifo_rdata[w_sel_idx*DATA_W +: DATA_W];
      r_src   <= w_sel_idx;
      r_ptr   <= w_sel_idx;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;

endmodule
